fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 32 +++
 rtl/fetch_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/response interface
//
// Purpose: groups the single-outstanding instruction memory handshake.
// Ports (signals):
//   imem_req    fetch -> mem  request strobe, held until imem_valid
//   imem_addr   fetch -> mem  request address, held until imem_valid
//   imem_valid  mem -> fetch  response strobe, imem_rdata valid this cycle
//   imem_rdata  mem -> fetch  32-bit instruction word
// Modports: master = fetch side, slave = memory side.

interface fetch_unit_if #(
   parameter int PC_W = 64
);
   logic            imem_req;
   logic [PC_W-1:0] imem_addr;
   logic            imem_valid;
   logic [31:0]     imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_valid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_valid,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with IF/ID register, skid buffer and branch drain
//
// Purpose: generates sequential instruction fetches, fills the IF/ID pipeline
// register, absorbs a response that lands during a stall, and redirects on a
// taken branch while discarding any in-flight response.
// Ports:
//   clk            in   single clock, rising edge
//   arst_n         in   asynchronous active-low reset
//   stall          in   freeze pc and IF/ID (hazard hold)
//   branch_taken   in   redirect request, highest priority
//   branch_target  in   redirect address, forced to word alignment
//   imem           if   master side of the instruction memory handshake
//   pc_IF_ID       out  pc of the instruction held in IF/ID
//   instr_IF_ID    out  instruction held in IF/ID
//   valid_IF_ID    out  IF/ID holds a live instruction (0 = bubble)

module fetch_unit #(
   parameter int              PC_W     = 64,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                arst_n,
   input  logic                stall,
   input  logic                branch_taken,
   input  logic [PC_W-1:0]     branch_target,
   fetch_unit_if.master        imem,
   output logic [PC_W-1:0]     pc_IF_ID,
   output logic [31:0]         instr_IF_ID,
   output logic                valid_IF_ID
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [PC_W-1:0]   pc_q, pc_d;
   logic [PC_W-1:0]   if_pc_q, if_pc_d;
   logic [31:0]       if_instr_q, if_instr_d;
   logic              if_valid_q, if_valid_d;
   logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
   logic [31:0]       skid_instr_q, skid_instr_d;
   logic              skid_valid_q, skid_valid_d;
   logic [PC_W-1:0]   drain_addr_q, drain_addr_d;

   logic              req_c;
   logic [PC_W-1:0]   addr_c;
   logic              resp_c;
   logic [PC_W-1:0]   pc_inc_c;
   logic [PC_W-1:0]   target_c;

   // Request is driven only while a fetch is owed to memory; in DRAIN the
   // address of the abandoned request is replayed so the bus stays stable.
   assign req_c    = (state_q == S_FETCH) || (state_q == S_DRAIN);
   assign addr_c   = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
   // A strobe with no request outstanding (e.g. a stale response after reset)
   // must not be consumed.
   assign resp_c   = imem.imem_valid && req_c;
   assign pc_inc_c = pc_q + PC_W'(4);
   assign target_c = branch_target & ~PC_W'(3);

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      if_pc_d      = if_pc_q;
      if_instr_d   = if_instr_q;
      if_valid_d   = if_valid_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      skid_valid_d = skid_valid_q;
      drain_addr_d = drain_addr_q;

      if (branch_taken) begin
         // Redirect beats stall and any response; IF/ID becomes a bubble
         // while its payload is left in place.
         pc_d         = target_c;
         if_valid_d   = 1'b0;
         skid_valid_d = 1'b0;
         unique case (state_q)
            S_FETCH: begin
               if (resp_c) begin
                  state_d = S_FETCH;
               end else begin
                  // Memory still owes a response to pc_q; wait it out.
                  state_d      = S_DRAIN;
                  drain_addr_d = pc_q;
               end
            end
            S_DRAIN: begin
               state_d = resp_c ? S_FETCH : S_DRAIN;
            end
            default: begin
               state_d = S_FETCH;
            end
         endcase
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_d = S_FETCH;
            end
            S_FETCH: begin
               if (resp_c) begin
                  if (stall) begin
                     skid_pc_d    = pc_q;
                     skid_instr_d = imem.imem_rdata;
                     skid_valid_d = 1'b1;
                     state_d      = S_HOLD;
                  end else begin
                     if_pc_d    = pc_q;
                     if_instr_d = imem.imem_rdata;
                     if_valid_d = 1'b1;
                     pc_d       = pc_inc_c;
                  end
               end else if (!stall) begin
                  // Decode consumed IF/ID and nothing replaced it.
                  if_valid_d = 1'b0;
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  if_pc_d      = skid_pc_q;
                  if_instr_d   = skid_instr_q;
                  if_valid_d   = skid_valid_q;
                  skid_valid_d = 1'b0;
                  pc_d         = pc_inc_c;
                  state_d      = S_FETCH;
               end
            end
            S_DRAIN: begin
               if (resp_c) begin
                  state_d = S_FETCH;
               end
               if (!stall) begin
                  if_valid_d = 1'b0;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         if_pc_q      <= '0;
         if_instr_q   <= '0;
         if_valid_q   <= 1'b0;
         skid_pc_q    <= '0;
         skid_instr_q <= '0;
         skid_valid_q <= 1'b0;
         drain_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         if_pc_q      <= if_pc_d;
         if_instr_q   <= if_instr_d;
         if_valid_q   <= if_valid_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
         skid_valid_q <= skid_valid_d;
         drain_addr_q <= drain_addr_d;
      end
   end

   assign imem.imem_req  = req_c;
   assign imem.imem_addr = addr_c;
   assign pc_IF_ID       = if_pc_q;
   assign instr_IF_ID    = if_instr_q;
   assign valid_IF_ID    = if_valid_q;

endmodule
